// File: rtl/ram_fifo_ctrl_128x128.sv
// Sequencing controller that runs a 128x128 two-port RAM as a 128-entry FIFO.
// The RAM read register doubles as the output slot, so rd_pd comes straight from ram_dout.
module ram_fifo_ctrl_128x128 (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_pvld,
  output logic         wr_prdy,
  input  logic [127:0] wr_pd,
  output logic         rd_pvld,
  input  logic         rd_prdy,
  output logic [127:0] rd_pd,
  output logic         ram_we,
  output logic [6:0]   ram_wa,
  output logic [127:0] ram_di,
  output logic         ram_re,
  output logic [6:0]   ram_ra,
  input  logic [127:0] ram_dout,
  output logic [7:0]   count,
  output logic         idle
);

  localparam int unsigned DEPTH = 128;
  localparam int unsigned AW    = 7;
  localparam int unsigned CW    = 8;

  typedef enum logic [0:0] {StEmpty, StValid} out_state_e;

  out_state_e      state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   pend;
  logic            out_vld;
  logic            push;
  logic            pop;

  always_comb begin
    out_vld = (state_q == StValid);
    // Full check includes the presented entry, so its RAM slot is never overwritten.
    wr_prdy = !rst && (count_q != CW'(DEPTH));
    push    = wr_pvld && wr_prdy;
    pop     = out_vld && rd_prdy;
    // Entries written but not yet read-issued; a same-cycle push is not counted.
    pend    = count_q - CW'(out_vld);
    ram_re  = !rst && (pend != '0) && (!out_vld || rd_prdy);

    wr_ptr_d = push   ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = ram_re ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);

    state_d = state_q;
    unique case (state_q)
      StEmpty: if (ram_re) state_d = StValid;
      StValid: if (pop && !ram_re) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
  end

  always_comb begin
    ram_we  = push;
    ram_wa  = wr_ptr_q;
    ram_di  = wr_pd;
    ram_ra  = rd_ptr_q;
    rd_pvld = out_vld;
    rd_pd   = ram_dout;
    count   = count_q;
    idle    = (count_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StEmpty;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
